fir_mac_seq: RTL and testbench
==============================

// Module: fir_mac_seq
// PURPOSE
//  Sequential FIR core stage that consumes the 16-bit sample stream produced by the reg_16 input register.
//  - Keeps a TAPS-deep sample history and a programmable coefficient bank.
//  - Computes one output per accepted sample with a single multiplier, one tap per cycle.
//  - Delivers the scaled, saturated result on a valid/ready output towards the output register stage.
// PARAMETERS
//  TAPS       8   number of filter taps (power of 2, >=2)
//  DW         16  sample and output width, signed two's complement
//  CW         16  coefficient width, signed two's complement
//  AW         3   tap index width, log2(TAPS)
//  ACC_W      35  accumulator width, DW+CW+AW; overflow impossible
//  OUT_SHIFT  15  arithmetic right shift applied to accumulator (Q15 coefficients)
// PORTS
//  CLK        in   1      clock, all state updates on rising edge
//  RESET      in   1      asynchronous, active-high reset
//  IN_VALID   in   1      DATA_IN holds a new sample
//  IN_READY   out  1      block accepts a sample this cycle
//  DATA_IN    in   DW     input sample (signed)
//  COEF_WE    in   1      coefficient write strobe
//  COEF_ADDR  in   AW     coefficient index to write
//  COEF_DATA  in   CW     coefficient value (signed)
//  OUT_VALID  out  1      DATA_OUT holds a finished result
//  OUT_READY  in   1      downstream consumes result this cycle
//  DATA_OUT   out  DW     filtered output (signed, saturated)
//  BUSY       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset values while RESET=1, asynchronous:
//   - state=IDLE; all sample history x[0..TAPS-1]=0; all coefficients c[0..TAPS-1]=0.
//   - accumulator=0; DATA_OUT=0; OUT_VALID=0; BUSY=0; IN_READY=1.
//  Reset mid-operation aborts the computation with no output and clears history and coefficients.
//  FSM IDLE -> MAC -> SAT -> OUT -> IDLE:
//   - IDLE: IN_READY=1. On IN_VALID&IN_READY at edge k:
//     x[i]<=x[i-1] for i=1..TAPS-1, x[0]<=DATA_IN, acc<=0, idx<=0, go MAC.
//   - MAC: each edge acc<=acc+sext(x[idx]*c[idx]) (full signed 32-bit product), idx<=idx+1.
//     Leave for SAT on the edge where idx==TAPS-1, so exactly TAPS products are summed.
//   - SAT: one edge. t=acc>>>OUT_SHIFT (floor, no rounding); clamp to [-32768, 32767].
//     DATA_OUT<=clamp(t), OUT_VALID<=1, go OUT.
//   - OUT: DATA_OUT and OUT_VALID held stable until OUT_READY=1.
//     On that edge OUT_VALID<=0 and state goes to IDLE.
//  Latency: OUT_VALID rises on edge k+TAPS+1, i.e. 9 cycles after acceptance for TAPS=8.
//  Throughput: at most 1 sample per TAPS+3 cycles, 11 cycles with zero backpressure.
//  IN_READY is combinational: IN_READY = (state==IDLE). It is 0 in MAC, SAT and OUT.
//   - A sample presented while IN_READY=0 is not consumed and must be held by the sender.
//  Coefficient writes: c[COEF_ADDR]<=COEF_DATA on an edge with COEF_WE=1, only when state==IDLE.
//   - Writes in any other state are ignored, so coefficients cannot change during a computation.
//   - A simultaneous coefficient write and sample accept in IDLE is allowed.
//     The new coefficient is used by that computation.
//  x[0] is the newest sample, x[TAPS-1] the oldest. The output is y[n] = sum_k c[k]*x[n-k].
//  DATA_OUT keeps its last value after the handshake until the next SAT state.
// TESTING
//  1) Reset, no coefficient writes, send 350 -> OUT_VALID after 9 cycles, DATA_OUT=0.
//  2) c[0]=16384, others 0, send 350 -> DATA_OUT=175. Send -350 -> DATA_OUT=-175.
//  3) c[k]=2*(k+1); send 16384 then nine zeros -> outputs 1,2,3,4,5,6,7,8,0,0.
//  4) All c=32767, eight samples of 32767 -> 8th DATA_OUT=32767 (saturated).
//     Eight samples of -32768 -> DATA_OUT=-32768 (saturated).
//  5) Hold OUT_READY=0 for 5 cycles in OUT -> DATA_OUT, OUT_VALID stable, IN_READY=0, COEF_WE ignored.
//     After release, the next sample is accepted one cycle later.
//  6) Assert RESET on the 3rd MAC cycle -> OUT_VALID stays 0, IN_READY=1, BUSY=0.
//     After release, sending 350 with c[0]=16384 rewritten gives DATA_OUT=175; older history reads 0.

Source files
------------

// File: rtl/fir_mac_seq.sv
// Sequential FIR stage: TAPS-deep history and a programmable coefficient bank.
// One multiply-accumulate per cycle; scaled, saturated result on valid/ready.
module fir_mac_seq #(
    parameter int TAPS      = 8,
    parameter int DW        = 16,
    parameter int CW        = 16,
    parameter int AW        = 3,
    parameter int ACC_W     = 35,
    parameter int OUT_SHIFT = 15
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          IN_VALID,
    output logic          IN_READY,
    input  logic [DW-1:0] DATA_IN,
    input  logic          COEF_WE,
    input  logic [AW-1:0] COEF_ADDR,
    input  logic [CW-1:0] COEF_DATA,
    output logic          OUT_VALID,
    input  logic          OUT_READY,
    output logic [DW-1:0] DATA_OUT,
    output logic          BUSY
);

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        SAT,
        OUT
    } state_t;

    localparam int PW = DW + CW;

    state_t state;
    state_t state_nxt;

    logic signed [DW-1:0]    x [TAPS];
    logic signed [CW-1:0]    c [TAPS];
    logic signed [ACC_W-1:0] acc;
    logic [AW-1:0]           idx;

    logic                    accept;
    logic                    last_tap;
    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] prod_ext;
    logic signed [ACC_W-1:0] scaled;
    logic                    fits;
    logic [DW-1:0]           sat_val;

    assign accept   = IN_VALID && (state == IDLE);
    assign last_tap = (idx == AW'(TAPS - 1));

    // Full-width signed product of the current tap, sign-extended into the accumulator.
    assign prod     = PW'(x[idx]) * PW'(c[idx]);
    assign prod_ext = {{(ACC_W - PW){prod[PW-1]}}, prod};

    // Floor scaling, then clamp when the discarded upper bits are not pure sign.
    assign scaled   = acc >>> OUT_SHIFT;
    assign fits     = (&scaled[ACC_W-1:DW-1]) | ~(|scaled[ACC_W-1:DW-1]);
    assign sat_val  = fits ? scaled[DW-1:0]
                    : (scaled[ACC_W-1] ? {1'b1, {(DW-1){1'b0}}}
                                       : {1'b0, {(DW-1){1'b1}}});

    // State register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        BUSY      = 1'b1;
        unique case (state)
            IDLE: begin
                IN_READY = 1'b1;
                BUSY     = 1'b0;
                if (IN_VALID) state_nxt = MAC;
            end
            MAC: if (last_tap) state_nxt = SAT;
            SAT: state_nxt = OUT;
            OUT: if (OUT_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // History shift, coefficient bank, accumulator and output register.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            for (int i = 0; i < TAPS; i++) begin
                x[i] <= '0;
                c[i] <= '0;
            end
            acc       <= '0;
            idx       <= '0;
            DATA_OUT  <= '0;
            OUT_VALID <= 1'b0;
        end else begin
            if (COEF_WE && (state == IDLE)) begin
                c[COEF_ADDR] <= COEF_DATA;
            end
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        for (int i = 1; i < TAPS; i++) begin
                            x[i] <= x[i-1];
                        end
                        x[0] <= DATA_IN;
                        acc  <= '0;
                        idx  <= '0;
                    end
                end
                MAC: begin
                    acc <= acc + prod_ext;
                    idx <= idx + AW'(1);
                end
                SAT: begin
                    DATA_OUT  <= sat_val;
                    OUT_VALID <= 1'b1;
                end
                OUT: begin
                    if (OUT_READY) OUT_VALID <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_seq.sv
// Self-checking bench for fir_mac_seq: directed cases plus randomized
// samples/coefficients against a plain-arithmetic convolution model.
module tb_fir_mac_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] data_in;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] data_out;
    logic        busy;

    int checks = 0;
    int errors = 0;

    // Reference model state: newest sample at hist[0].
    longint hist [8];
    longint coef [8];

    fir_mac_seq dut (
        .CLK       (clk),
        .RESET     (rst),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .DATA_IN   (data_in),
        .COEF_WE   (coef_we),
        .COEF_ADDR (coef_addr),
        .COEF_DATA (coef_data),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .DATA_OUT  (data_out),
        .BUSY      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic longint model_y();
        longint sum = 0;
        longint t;
        for (int k = 0; k < 8; k++) sum += coef[k] * hist[k];
        t = sum >>> 15;
        if (t > 32767) t = 32767;
        if (t < -32768) t = -32768;
        return t;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 8; k++) begin
            hist[k] = 0;
            coef[k] = 0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_clear();
        tick();
    endtask

    task automatic write_coef(input int a, input int d);
        coef_we   = 1'b1;
        coef_addr = 3'(a);
        coef_data = 16'(d);
        tick();
        coef_we = 1'b0;
        coef[a] = longint'($signed(16'(d)));
    endtask

    // Send one sample, wait for the result, optionally stall the consumer.
    task automatic send(input int s, input int hold, input bit use_exp,
                        input longint exp);
        longint want;
        int n = 0;
        logic [15:0] held;
        check("in_ready_idle", in_ready, 1);
        in_valid = 1'b1;
        data_in  = 16'(s);
        tick();
        in_valid = 1'b0;
        for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(16'(s)));
        want = use_exp ? exp : model_y();
        check("busy_after_accept", busy, 1);
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("latency", n, 9);
        check("data_out", longint'($signed(data_out)), want);
        held = data_out;
        for (int h = 0; h < hold; h++) begin
            coef_we   = 1'b1;
            coef_addr = 3'($urandom_range(0, 7));
            coef_data = 16'($urandom);
            tick();
            check("hold_valid", out_valid, 1);
            check("hold_data", data_out, held);
            check("hold_in_ready", in_ready, 0);
        end
        coef_we   = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("valid_drop", out_valid, 0);
        check("ready_back", in_ready, 1);
        check("data_kept", data_out, held);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        data_in   = '0;
        coef_we   = 1'b0;
        coef_addr = '0;
        coef_data = '0;
        out_ready = 1'b0;
        model_clear();
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_data_out", data_out, 0);
        tick();
        rst = 1'b0;
        tick();

        // No coefficients loaded: output is zero.
        send(350, 0, 1, 0);

        // Single Q15 half-gain tap.
        write_coef(0, 16384);
        send(350, 0, 1, 175);
        send(-350, 0, 1, -175);

        // Impulse through a ramp of coefficients.
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 2 * (k + 1));
        send(16384, 0, 1, 1);
        for (int i = 0; i < 9; i++) send(0, 0, 1, (i < 7) ? i + 2 : 0);

        // Positive and negative saturation.
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, 32767);
        for (int i = 0; i < 8; i++) send(32767, 0, i == 7, 32767);
        for (int i = 0; i < 8; i++) send(-32768, 0, i == 7, -32768);

        // Back-pressure with ignored coefficient writes, then immediate reuse.
        send(1000, 5, 0, 0);
        send(-2000, 0, 0, 0);

        // Reset during the third MAC cycle.
        write_coef(1, 16384);
        send(700, 0, 0, 0);
        in_valid = 1'b1;
        data_in  = 16'd1234;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        tick();
        rst = 1'b0;
        model_clear();
        for (int i = 0; i < 12; i++) tick();
        check("post_rst_valid", out_valid, 0);
        write_coef(0, 16384);
        for (int k = 1; k < 8; k++) write_coef(k, 16384);
        send(350, 0, 1, 175);

        // Randomized samples, coefficients and stalls.
        do_reset();
        for (int k = 0; k < 8; k++) write_coef(k, int'($urandom_range(0, 65535)));
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                write_coef(int'($urandom_range(0, 7)), int'($urandom_range(0, 65535)));
            end
            send(int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)), 0, 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
